// File: rtl/smi_arbiter_if.sv
// rtl/smi_arbiter_if.sv - requester command/response and SMI engine signal bundle
interface smi_arbiter_if;
  logic [1:0]  cmd_valid;
  logic [1:0]  cmd_ready;
  logic [1:0]  cmd_we;
  logic [9:0]  cmd_phy;
  logic [9:0]  cmd_reg;
  logic [31:0] cmd_wdata;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [4:0]  smi_phy_addr;
  logic [4:0]  smi_reg_addr;
  logic [15:0] smi_write_data;
  logic        smi_write_req;
  logic        smi_read_req;
  logic [15:0] smi_read_data;
  logic        smi_data_valid;
  logic        smi_done;

  modport slave (
    input  cmd_valid, cmd_we, cmd_phy, cmd_reg, cmd_wdata,
    input  smi_read_data, smi_data_valid, smi_done,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
    output smi_phy_addr, smi_reg_addr, smi_write_data, smi_write_req, smi_read_req
  );

  modport master (
    output cmd_valid, cmd_we, cmd_phy, cmd_reg, cmd_wdata,
    output smi_read_data, smi_data_valid, smi_done,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
    input  smi_phy_addr, smi_reg_addr, smi_write_data, smi_write_req, smi_read_req
  );
endinterface

// File: rtl/smi_arbiter.sv
// rtl/smi_arbiter.sv - two-requester round-robin arbiter in front of one SMI engine
module smi_arbiter #(
  parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
  input logic          clk,
  input logic          rst_n,
  smi_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [4:0]  phy_q, phy_d;
  logic [4:0]  reg_q, reg_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] data_q, data_d;
  logic        err_q, err_d;
  logic [31:0] timer_q, timer_d;

  logic grant_any;
  logic grant_idx;

  // Contested requests go to whoever did not own the previous transaction.
  always_comb begin
    grant_any = |bus.cmd_valid;
    if (bus.cmd_valid == 2'b11) grant_idx = ~last_owner_q;
    else                        grant_idx = bus.cmd_valid[1];
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    phy_d        = phy_q;
    reg_d        = reg_q;
    wdata_d      = wdata_q;
    data_d       = data_q;
    err_d        = err_q;
    timer_d      = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          owner_d = grant_idx;
          we_d    = grant_idx ? bus.cmd_we[1] : bus.cmd_we[0];
          phy_d   = grant_idx ? bus.cmd_phy[9:5] : bus.cmd_phy[4:0];
          reg_d   = grant_idx ? bus.cmd_reg[9:5] : bus.cmd_reg[4:0];
          wdata_d = grant_idx ? bus.cmd_wdata[31:16] : bus.cmd_wdata[15:0];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        data_d  = '0;
        err_d   = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!we_q && bus.smi_data_valid) data_d = bus.smi_read_data;
        // A done arriving on the timeout cycle still counts as success.
        if (bus.smi_done) begin
          state_d = ST_RESP;
        end else if (timer_q == TIMEOUT) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          data_d  = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_RESP: begin
        last_owner_d = owner_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      phy_q        <= '0;
      reg_q        <= '0;
      wdata_q      <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      phy_q        <= phy_d;
      reg_q        <= reg_d;
      wdata_q      <= wdata_d;
      data_q       <= data_d;
      err_q        <= err_d;
      timer_q      <= timer_d;
    end
  end

  // Gated by rst_n so the grant is withheld while reset is still asserted.
  assign bus.cmd_ready      = (rst_n && state_q == ST_IDLE && grant_any) ? {grant_idx, ~grant_idx} : 2'b00;
  assign bus.rsp_valid      = (state_q == ST_RESP) ? {owner_q, ~owner_q} : 2'b00;
  assign bus.rsp_data       = (state_q == ST_RESP) ? data_q : 16'd0;
  assign bus.rsp_err        = (state_q == ST_RESP) && err_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.smi_phy_addr   = phy_q;
  assign bus.smi_reg_addr   = reg_q;
  assign bus.smi_write_data = wdata_q;
  assign bus.smi_write_req  = (state_q == ST_ISSUE) && we_q;
  assign bus.smi_read_req   = (state_q == ST_ISSUE) && !we_q;

endmodule
